l1_miss_arbiter: RTL

Shares one data-memory channel between the per-core L1 data caches. Each core's cache presents a single miss/writeback request port (one outstanding read or write). The arbiter grants one core at a time, round-robin, and forwards the request to the data memory controller. It returns the read data and a one-cycle ready pulse to the granted core, then waits for that core to drop its request before re-arbitrating.

---
 rtl/l1_miss_arbiter_if.sv | 35 +++
 rtl/l1_miss_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/l1_miss_arbiter_if.sv
// l1_miss_arbiter_if: core-side and memory-side buses of the L1 miss arbiter
interface l1_miss_arbiter_if #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic [NUM_CORES-1:0]                core_read_valid;
    logic [NUM_CORES-1:0][ADDR_BITS-1:0] core_read_address;
    logic [NUM_CORES-1:0]                core_read_ready;
    logic [NUM_CORES-1:0][DATA_BITS-1:0] core_read_data;
    logic [NUM_CORES-1:0]                core_write_valid;
    logic [NUM_CORES-1:0][ADDR_BITS-1:0] core_write_address;
    logic [NUM_CORES-1:0][DATA_BITS-1:0] core_write_data;
    logic [NUM_CORES-1:0]                core_write_ready;
    logic                                mem_read_valid;
    logic [ADDR_BITS-1:0]                mem_read_address;
    logic                                mem_read_ready;
    logic [DATA_BITS-1:0]                mem_read_data;
    logic                                mem_write_valid;
    logic [ADDR_BITS-1:0]                mem_write_address;
    logic [DATA_BITS-1:0]                mem_write_data;
    logic                                mem_write_ready;
    modport master (
        output core_read_valid, core_read_address, core_write_valid, core_write_address,
               core_write_data, mem_read_ready, mem_read_data, mem_write_ready,
        input  core_read_ready, core_read_data, core_write_ready, mem_read_valid,
               mem_read_address, mem_write_valid, mem_write_address, mem_write_data
    );
    modport slave (
        input  core_read_valid, core_read_address, core_write_valid, core_write_address,
               core_write_data, mem_read_ready, mem_read_data, mem_write_ready,
        output core_read_ready, core_read_data, core_write_ready, mem_read_valid,
               mem_read_address, mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/l1_miss_arbiter.sv
// l1_miss_arbiter: round-robin sharing of one data-memory channel among L1 caches (L1ARB_FIXED_PRIORITY_EN selects fixed priority)
module l1_miss_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input logic              clk,
    input logic              reset,
    l1_miss_arbiter_if.slave bus
);
    localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELEASE} state_t;

    state_t                              state_q, state_d;
    logic [GW-1:0]                       grant_q, grant_d;
    logic [GW-1:0]                       last_grant_q, last_grant_d;
    logic                                mem_read_valid_q, mem_read_valid_d;
    logic                                mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]                mem_read_address_q, mem_read_address_d;
    logic [ADDR_BITS-1:0]                mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]                mem_write_data_q, mem_write_data_d;
    logic [NUM_CORES-1:0]                core_read_ready_q, core_read_ready_d;
    logic [NUM_CORES-1:0]                core_write_ready_q, core_write_ready_d;
    logic [NUM_CORES-1:0][DATA_BITS-1:0] core_read_data_q, core_read_data_d;
    logic [NUM_CORES-1:0]                req;
    logic [GW-1:0]                       cand;
    logic [GW-1:0]                       pick;
    logic                                found;

    assign req = bus.core_read_valid | bus.core_write_valid;

    // Find the first requesting core after the last grant (or from core 0 in fixed-priority builds)
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NUM_CORES; i++) begin
`ifdef L1ARB_FIXED_PRIORITY_EN
            cand = GW'(i - 1);
`else
            cand = GW'((int'(last_grant_q) + i) % NUM_CORES);
`endif
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and registered-output computation for the grant/handshake/release cycle
    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        last_grant_d        = last_grant_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        core_read_ready_d   = '0;
        core_write_ready_d  = '0;
        core_read_data_d    = core_read_data_q;
        case (state_q)
            IDLE: if (found) begin
                grant_d      = pick;
                last_grant_d = pick;
                if (bus.core_read_valid[pick]) begin
                    mem_read_valid_d   = 1'b1;
                    mem_read_address_d = bus.core_read_address[pick];
                    state_d            = READ_WAIT;
                end else begin
                    mem_write_valid_d   = 1'b1;
                    mem_write_address_d = bus.core_write_address[pick];
                    mem_write_data_d    = bus.core_write_data[pick];
                    state_d             = WRITE_WAIT;
                end
            end
            READ_WAIT: if (bus.mem_read_ready) begin
                core_read_data_d[grant_q]  = bus.mem_read_data;
                core_read_ready_d[grant_q] = 1'b1;
                mem_read_valid_d           = 1'b0;
                state_d                    = RELEASE;
            end
            WRITE_WAIT: if (bus.mem_write_ready) begin
                core_write_ready_d[grant_q] = 1'b1;
                mem_write_valid_d           = 1'b0;
                state_d                     = RELEASE;
            end
            RELEASE: state_d = req[grant_q] ? RELEASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= IDLE;
            grant_q             <= '0;
            last_grant_q        <= GW'(NUM_CORES - 1);
            mem_read_valid_q    <= 1'b0;
            mem_write_valid_q   <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            core_read_ready_q   <= '0;
            core_write_ready_q  <= '0;
            core_read_data_q    <= '0;
        end else begin
            state_q             <= state_d;
            grant_q             <= grant_d;
            last_grant_q        <= last_grant_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            core_read_ready_q   <= core_read_ready_d;
            core_write_ready_q  <= core_write_ready_d;
            core_read_data_q    <= core_read_data_d;
        end
    end

    assign bus.mem_read_valid    = mem_read_valid_q;
    assign bus.mem_read_address  = mem_read_address_q;
    assign bus.mem_write_valid   = mem_write_valid_q;
    assign bus.mem_write_address = mem_write_address_q;
    assign bus.mem_write_data    = mem_write_data_q;
    assign bus.core_read_ready   = core_read_ready_q;
    assign bus.core_write_ready  = core_write_ready_q;
    assign bus.core_read_data    = core_read_data_q;
endmodule
